// File: rtl/fir_decim_out_if.sv
// Stream bundle for fir_decim_out: FIR-side input stream plus the decimated ready/valid output.
// master drives samples and out_ready; slave (the decimator) returns out_valid/out_data.
interface fir_decim_out_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output valid_in, data_in, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  valid_in, data_in, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/fir_decim_out.sv
// Decimate-by-DECIM output stage with FIFO and sticky overflow. Define FIR_DECIM_AVG_EN to store
// the floor-average of each group instead of its last sample.
module fir_decim_out #(
    parameter int DATA_WIDTH = 16,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    fir_decim_out_if.slave                bus,
    input  logic                          clear_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    // Handshake: a sample is accepted when valid_in=1 (no backpressure upstream);
    // the head transfers when out_valid & out_ready, and out_valid/out_data hold otherwise.
    localparam int PW    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int SHIFT = $clog2(DECIM);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    logic [PW-1:0]         phase_q, phase_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         left;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] push_data;
    logic                  keep, pop, full, drop, push;

`ifdef FIR_DECIM_AVG_EN
    localparam int ACCW = DATA_WIDTH + SHIFT;
    logic signed [ACCW-1:0] acc_q, acc_d, sum;

    always_comb begin
        sum       = acc_q + ACCW'($signed(bus.data_in));
        push_data = DATA_WIDTH'(sum >>> SHIFT);
        acc_d     = acc_q;
        if (bus.valid_in) begin
            acc_d = keep ? '0 : sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    always_comb begin
        push_data = bus.data_in;
    end
`endif

    always_comb begin
        keep = bus.valid_in && (phase_q == PW'(DECIM - 1));
        pop  = out_valid_q && bus.out_ready;
        full = (count_q == CW'(FIFO_DEPTH));
        drop = keep && full && !pop;
        push = keep && !drop;

        phase_d = phase_q;
        if (bus.valid_in) begin
            phase_d = keep ? '0 : phase_q + 1'b1;
        end

        wr_ptr_d    = wr_ptr_q + AW'(push);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        count_d     = count_q + CW'(push) - CW'(pop);
        left        = count_q - CW'(pop);
        out_valid_d = (count_d != '0);

        // Head after this edge: an older entry if one survives the pop, else the new push.
        out_data_d = out_data_q;
        if (left != '0) begin
            out_data_d = mem_q[rd_ptr_d];
        end else if (push) begin
            out_data_d = push_data;
        end

        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clear_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign fifo_count    = count_q;
    assign overflow      = ovf_q;
endmodule

// File: tb/tb_fir_decim_out.sv
// Directed bench for fir_decim_out (DECIM=4, FIFO_DEPTH=4); expected values follow FIR_DECIM_AVG_EN.
module tb_fir_decim_out;
    logic       clk = 1'b0;
    logic       rst;
    logic       clear_ovf;
    logic [2:0] fifo_count;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    fir_decim_out_if #(.DATA_WIDTH(16)) bus();

    fir_decim_out #(.DATA_WIDTH(16), .DECIM(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clear_ovf  (clear_ovf),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

`ifdef FIR_DECIM_AVG_EN
    localparam logic [15:0] K1 = 16'h0280;
    localparam logic [15:0] K2 = 16'h0680;
`else
    localparam logic [15:0] K1 = 16'h0400;
    localparam logic [15:0] K2 = 16'h0800;
`endif
    // Group -0x100,-0x100,-0x100,-0x101: last = 0xFEFF, floor(-0x401/4) = -0x101 = 0xFEFF.
    localparam logic [15:0] KNEG = 16'hFEFF;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        rdy;
        logic        ev;
        logic [15:0] ed;
        logic [2:0]  ec;
    } vec_t;

    vec_t tbl[$];

    // Expected kept value of group g when sample k carries k*0x10.
    function automatic logic [15:0] grp(input int g);
`ifdef FIR_DECIM_AVG_EN
        return 16'((16 * g - 6) * 4);
`else
        return 16'(4 * g * 16);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [15:0] d);
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        step();
        bus.valid_in = 1'b0;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.valid_in = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic add(input logic v, input logic [15:0] d, input logic ev,
                       input logic [15:0] ed, input logic [2:0] ec);
        tbl.push_back('{v: v, d: d, rdy: 1'b1, ev: ev, ed: ed, ec: ec});
    endtask

    initial begin
        rst           = 1'b1;
        clear_ovf     = 1'b0;
        bus.valid_in  = 1'b1;
        bus.data_in   = 16'h1234;
        bus.out_ready = 1'b0;

        // Reset held three cycles with valid_in asserted.
        repeat (3) step();
        check("rst out_valid", 32'(bus.out_valid), 0);
        check("rst fifo_count", 32'(fifo_count), 0);
        check("rst overflow", 32'(overflow), 0);
        check("rst out_data", 32'(bus.out_data), 0);
        rst          = 1'b0;
        bus.valid_in = 1'b0;

        // Back-to-back 1..8, then gapped 1..8, then a negative group.
        for (int i = 1; i <= 8; i++) begin
            add(1'b1, 16'(i * 256), (i % 4) == 0, (i == 4) ? K1 : K2, ((i % 4) == 0) ? 3'd1 : 3'd0);
        end
        add(1'b0, 16'h0, 1'b0, 16'h0, 3'd0);
        for (int i = 1; i <= 8; i++) begin
            add(1'b1, 16'(i * 256), (i % 4) == 0, (i == 4) ? K1 : K2, ((i % 4) == 0) ? 3'd1 : 3'd0);
            add(1'b0, 16'h0, 1'b0, 16'h0, 3'd0);
        end
        for (int i = 0; i < 3; i++) add(1'b1, 16'hFF00, 1'b0, 16'h0, 3'd0);
        add(1'b1, 16'hFEFF, 1'b1, KNEG, 3'd1);
        add(1'b0, 16'h0, 1'b0, 16'h0, 3'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            bus.valid_in  = tbl[i].v;
            bus.data_in   = tbl[i].d;
            bus.out_ready = tbl[i].rdy;
            step();
            check($sformatf("row%0d out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ev));
            check($sformatf("row%0d fifo_count", i), 32'(fifo_count), 32'(tbl[i].ec));
            check($sformatf("row%0d overflow", i), 32'(overflow), 0);
            if (tbl[i].ev) begin
                check($sformatf("row%0d out_data", i), 32'(bus.out_data), 32'(tbl[i].ed));
            end
        end
        bus.valid_in = 1'b0;

        // Backpressure: five keeps into four entries, fifth dropped.
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 20; i++) feed(16'(i * 16));
        check("bp fifo_count", 32'(fifo_count), 4);
        check("bp overflow", 32'(overflow), 1);
        check("bp out_valid", 32'(bus.out_valid), 1);
        for (int g = 1; g <= 4; g++) exp_q.push_back(grp(g));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp drain%0d valid", i), 32'(bus.out_valid), 1);
            check($sformatf("bp drain%0d data", i), 32'(bus.out_data), 32'(exp_q.pop_front()));
            step();
        end
        bus.out_ready = 1'b0;
        check("bp empty valid", 32'(bus.out_valid), 0);
        check("bp empty count", 32'(fifo_count), 0);
        check("bp ovf sticky", 32'(overflow), 1);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        check("bp ovf cleared", 32'(overflow), 0);

        // Full FIFO: keep and pop on the same edge.
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 16; i++) feed(16'(i * 16));
        check("fp full count", 32'(fifo_count), 4);
        check("fp full ovf", 32'(overflow), 0);
        for (int i = 17; i <= 19; i++) feed(16'(i * 16));
        bus.valid_in  = 1'b1;
        bus.data_in   = 16'(20 * 16);
        bus.out_ready = 1'b1;
        step();
        bus.valid_in = 1'b0;
        check("fp count held", 32'(fifo_count), 4);
        check("fp no ovf", 32'(overflow), 0);
        for (int g = 2; g <= 5; g++) exp_q.push_back(grp(g));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fp drain%0d valid", i), 32'(bus.out_valid), 1);
            check($sformatf("fp drain%0d data", i), 32'(bus.out_data), 32'(exp_q.pop_front()));
            step();
        end
        check("fp drained count", 32'(fifo_count), 0);
        check("fp drained valid", 32'(bus.out_valid), 0);

        // Mid-stream reset with two entries and phase 2.
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) feed(16'(i * 16));
        check("mr pre count", 32'(fifo_count), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr valid", 32'(bus.out_valid), 0);
        check("mr count", 32'(fifo_count), 0);
        for (int i = 1; i <= 3; i++) begin
            feed(16'(i * 16));
            check($sformatf("mr partial%0d count", i), 32'(fifo_count), 0);
            check($sformatf("mr partial%0d valid", i), 32'(bus.out_valid), 0);
        end
        feed(16'(4 * 16));
        check("mr keep valid", 32'(bus.out_valid), 1);
        check("mr keep count", 32'(fifo_count), 1);
        check("mr keep data", 32'(bus.out_data), 32'(grp(1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
